// File: rtl/itof_sched_if.sv
// Bundle of the two requester channels, the result channel and the busy flag of itof_sched.
// The slave modport is the scheduler side; the master modport is the surrounding environment.
interface itof_sched_if #(
  parameter int unsigned TAG_W = 5
);
  logic             req0_valid;
  logic             req0_ready;
  logic [31:0]      req0_data;
  logic [TAG_W-1:0] req0_tag;
  logic             req1_valid;
  logic             req1_ready;
  logic [31:0]      req1_data;
  logic [TAG_W-1:0] req1_tag;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;
  logic [TAG_W-1:0] res_tag;
  logic             res_src;
  logic             busy;

  modport master (
    output req0_valid, req0_data, req0_tag,
    input  req0_ready,
    output req1_valid, req1_data, req1_tag,
    input  req1_ready,
    input  res_valid, res_data, res_tag, res_src,
    output res_ready,
    input  busy
  );

  modport slave (
    input  req0_valid, req0_data, req0_tag,
    output req0_ready,
    input  req1_valid, req1_data, req1_tag,
    output req1_ready,
    output res_valid, res_data, res_tag, res_src,
    input  res_ready,
    output busy
  );
endinterface

// File: rtl/itof_sched.sv
// Round-robin arbiter feeding one shared int32->float32 converter through two register stages.
// Results return in acceptance order, tagged with source and destination tag.
module itof_sched #(
  parameter int unsigned TAG_W = 5
) (
  input logic        clk,
  input logic        rst,
  itof_sched_if.slave bus
);

  // Signed int32 to IEEE-754 single, round-to-nearest-even.
  function automatic logic [31:0] itof(input logic [31:0] a);
    logic        sgn;
    logic [31:0] mag;
    logic [31:0] norm;
    logic [4:0]  msb;
    logic        rnd;
    sgn = a[31];
    mag = sgn ? (~a + 32'd1) : a;
    msb = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (mag[i]) msb = 5'(i);
    end
    norm = mag << (5'd31 - msb);
    rnd  = norm[7] & ((|norm[6:0]) | norm[8]);
    // Mantissa carry-out ripples into the exponent field on its own.
    if (mag == 32'd0) return 32'd0;
    return {sgn, 8'd127 + {3'd0, msb}, norm[30:8]} + {31'd0, rnd};
  endfunction

  logic             s1_v_q, s1_v_d;
  logic [31:0]      s1_data_q, s1_data_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic             s1_src_q, s1_src_d;
  logic             s2_v_q, s2_v_d;
  logic [31:0]      s2_data_q, s2_data_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
  logic             s2_src_q, s2_src_d;
  logic             pri_q, pri_d;
  logic             adv2, acc1, grant0, grant1;
  logic [31:0]      conv;

  always_comb begin
    adv2   = s1_v_q & (~s2_v_q | bus.res_ready);
    acc1   = (~s1_v_q | adv2) & ~rst;
    grant0 = acc1 & bus.req0_valid & (~bus.req1_valid | ~pri_q);
    grant1 = acc1 & bus.req1_valid & (~bus.req0_valid | pri_q);
    conv   = itof(s1_data_q);

    pri_d     = pri_q;
    s1_v_d    = s1_v_q;
    s1_data_d = s1_data_q;
    s1_tag_d  = s1_tag_q;
    s1_src_d  = s1_src_q;
    s2_v_d    = s2_v_q;
    s2_data_d = s2_data_q;
    s2_tag_d  = s2_tag_q;
    s2_src_d  = s2_src_q;

    if (grant0 | grant1) begin
      pri_d     = grant0;
      s1_v_d    = 1'b1;
      s1_data_d = grant1 ? bus.req1_data : bus.req0_data;
      s1_tag_d  = grant1 ? bus.req1_tag : bus.req0_tag;
      s1_src_d  = grant1;
    end else if (adv2) begin
      s1_v_d = 1'b0;
    end

    if (adv2) begin
      s2_v_d    = 1'b1;
      s2_data_d = conv;
      s2_tag_d  = s1_tag_q;
      s2_src_d  = s1_src_q;
    end else if (s2_v_q & bus.res_ready) begin
      s2_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pri_q     <= 1'b0;
      s1_v_q    <= 1'b0;
      s1_data_q <= '0;
      s1_tag_q  <= '0;
      s1_src_q  <= 1'b0;
      s2_v_q    <= 1'b0;
      s2_data_q <= '0;
      s2_tag_q  <= '0;
      s2_src_q  <= 1'b0;
    end else begin
      pri_q     <= pri_d;
      s1_v_q    <= s1_v_d;
      s1_data_q <= s1_data_d;
      s1_tag_q  <= s1_tag_d;
      s1_src_q  <= s1_src_d;
      s2_v_q    <= s2_v_d;
      s2_data_q <= s2_data_d;
      s2_tag_q  <= s2_tag_d;
      s2_src_q  <= s2_src_d;
    end
  end

  always_comb begin
    bus.req0_ready = grant0;
    bus.req1_ready = grant1;
    bus.res_valid  = s2_v_q;
    bus.res_data   = s2_data_q;
    bus.res_tag    = s2_tag_q;
    bus.res_src    = s2_src_q;
    bus.busy       = s1_v_q | s2_v_q;
  end

endmodule

// File: tb/tb_itof_sched.sv
// Self-checking bench for itof_sched: directed scenarios plus a randomized run scored against
// a float model derived from the host's double-precision conversion.
module tb_itof_sched;
  localparam int unsigned TAG_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  itof_sched_if #(.TAG_W(TAG_W)) bus ();
  itof_sched #(.TAG_W(TAG_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Exact int->double, then round the double mantissa to 23 bits (nearest-even).
  function automatic logic [31:0] ref_itof(input logic signed [31:0] v);
    real         r;
    logic [63:0] b;
    logic [10:0] e;
    logic [51:0] m;
    logic        rnd;
    if (v == 0) return 32'd0;
    r   = $itor(v);
    b   = $realtobits(r);
    e   = b[62:52];
    m   = b[51:0];
    rnd = m[28] & ((|m[27:0]) | m[29]);
    return {b[63], 8'(e - 11'd896), m[51:29]} + {31'd0, rnd};
  endfunction

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_data = '0; bus.req0_tag = '0;
    bus.req1_valid = 1'b0; bus.req1_data = '0; bus.req1_tag = '0;
    bus.res_ready  = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready got %b want 00", {bus.req0_ready, bus.req1_ready});
    end
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    #1;
    checks++;
    if ({bus.res_valid, bus.res_data, bus.res_tag, bus.res_src, bus.busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b d=%h t=%0d s=%b busy=%b want all 0", bus.res_valid,
               bus.res_data, bus.res_tag, bus.res_src, bus.busy);
    end
    @(negedge clk);
  endtask

  task automatic test_single();
    idle_inputs();
    bus.req0_valid = 1'b1; bus.req0_data = 32'h1; bus.req0_tag = 5'd3;
    #1;
    checks++;
    if (bus.req0_ready !== 1'b1) begin
      errors++; $display("FAIL single_ready got %b want 1", bus.req0_ready);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (bus.res_valid !== 1'b0) begin
      errors++; $display("FAIL single_early got res_valid=%b want 0", bus.res_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({bus.res_valid, bus.res_data, bus.res_tag, bus.res_src} !==
        {1'b1, 32'h3F80_0000, 5'd3, 1'b0}) begin
      errors++;
      $display("FAIL single_result got v=%b d=%h t=%0d s=%b want 1 3f800000 3 0",
               bus.res_valid, bus.res_data, bus.res_tag, bus.res_src);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.res_valid !== 1'b0) begin
      errors++; $display("FAIL single_once got res_valid=%b want 0", bus.res_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_corners();
    logic [31:0] vin [4];
    logic [31:0] vout[4];
    vin  = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'd16777217};
    vout = '{32'h0, 32'hBF80_0000, 32'hCF00_0000, 32'h4B80_0000};
    idle_inputs();
    for (int c = 0; c < 6; c++) begin
      bus.req1_valid = (c < 4);
      bus.req1_data  = (c < 4) ? vin[c] : 32'h0;
      bus.req1_tag   = 5'(10 + c);
      #1;
      if (c < 4) begin
        checks++;
        if (bus.req1_ready !== 1'b1) begin
          errors++; $display("FAIL corner_ready[%0d] got %b want 1", c, bus.req1_ready);
        end
      end
      if (c >= 2) begin
        checks++;
        if ({bus.res_valid, bus.res_data, bus.res_tag, bus.res_src} !==
            {1'b1, vout[c-2], 5'(10 + c - 2), 1'b1}) begin
          errors++;
          $display("FAIL corner_result[%0d] got v=%b d=%h t=%0d s=%b want 1 %h %0d 1", c - 2,
                   bus.res_valid, bus.res_data, bus.res_tag, bus.res_src, vout[c-2], 10 + c - 2);
        end
      end
      @(negedge clk);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_contention();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      bus.req0_valid = (c < 6); bus.req0_data = 32'(c + 100); bus.req0_tag = 5'(c);
      bus.req1_valid = (c < 6); bus.req1_data = 32'(c + 200); bus.req1_tag = 5'(c);
      #1;
      if (c < 6) begin
        checks++;
        if ({bus.req0_ready, bus.req1_ready} !== ((c % 2 == 0) ? 2'b10 : 2'b01)) begin
          errors++;
          $display("FAIL contention_grant[%0d] got %b want %b", c,
                   {bus.req0_ready, bus.req1_ready}, (c % 2 == 0) ? 2'b10 : 2'b01);
        end
      end
      if (c >= 2) begin
        checks++;
        if ({bus.res_valid, bus.res_src} !== {1'b1, 1'((c - 2) % 2)}) begin
          errors++;
          $display("FAIL contention_src[%0d] got v=%b s=%b want 1 %0d", c - 2, bus.res_valid,
                   bus.res_src, (c - 2) % 2);
        end
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    logic [31:0] vals[6];
    int          idx = 0;
    int          got = 0;
    for (int i = 0; i < 6; i++) vals[i] = $urandom;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      bus.res_ready  = (c >= 4);
      bus.req0_valid = (idx < 6);
      bus.req0_data  = (idx < 6) ? vals[idx] : 32'h0;
      bus.req0_tag   = 5'(idx);
      #1;
      if (c == 2 || c == 3) begin
        checks++;
        if (bus.req0_ready !== 1'b0) begin
          errors++; $display("FAIL bp_ready_low[%0d] got %b want 0", c, bus.req0_ready);
        end
        checks++;
        if ({bus.res_valid, bus.res_data, bus.res_tag} !== {1'b1, ref_itof(vals[0]), 5'd0}) begin
          errors++;
          $display("FAIL bp_hold[%0d] got v=%b d=%h t=%0d want 1 %h 0", c, bus.res_valid,
                   bus.res_data, bus.res_tag, ref_itof(vals[0]));
        end
      end
      if (c == 4) begin
        checks++;
        if (bus.req0_ready !== 1'b1) begin
          errors++; $display("FAIL bp_release got ready=%b want 1", bus.req0_ready);
        end
      end
      if (c <= 4) begin
        checks++;
        if (bus.busy !== (c >= 1)) begin
          errors++; $display("FAIL bp_busy[%0d] got %b want %b", c, bus.busy, c >= 1);
        end
      end
      if (bus.res_valid && bus.res_ready) begin
        checks++;
        if (got >= 6 || {bus.res_data, bus.res_tag} !== {ref_itof(vals[got]), 5'(got)}) begin
          errors++;
          $display("FAIL bp_order[%0d] got d=%h t=%0d", got, bus.res_data, bus.res_tag);
        end
        got++;
      end
      if (bus.req0_valid && bus.req0_ready) idx++;
      @(negedge clk);
    end
    checks++;
    if (got !== 6 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL bp_count got %0d results busy=%b want 6 and 0", got, bus.busy);
    end
    idle_inputs();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    bus.res_ready  = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_data = 32'd77; bus.req0_tag = 5'd7;
    @(negedge clk);
    bus.req0_data = 32'd78; bus.req0_tag = 5'd8;
    @(negedge clk);
    rst = 1'b1;
    bus.req1_valid = 1'b1; bus.req1_data = 32'd5; bus.req1_tag = 5'd9;
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
      errors++; $display("FAIL mid_rst_ready got %b want 00", {bus.req0_ready, bus.req1_ready});
    end
    @(negedge clk);
    rst = 1'b0;
    bus.res_ready = 1'b1;
    bus.req0_data = 32'd2; bus.req0_tag = 5'd1;
    #1;
    checks++;
    if ({bus.res_valid, bus.busy, bus.res_data} !== {2'b00, 32'h0}) begin
      errors++;
      $display("FAIL mid_rst_clear got v=%b busy=%b d=%h want 0 0 0", bus.res_valid, bus.busy,
               bus.res_data);
    end
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      errors++; $display("FAIL mid_rst_pri got %b want 10", {bus.req0_ready, bus.req1_ready});
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (bus.res_valid !== 1'b0) begin
      errors++; $display("FAIL mid_rst_stale got res_valid=%b want 0", bus.res_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({bus.res_valid, bus.res_data, bus.res_tag, bus.res_src} !==
        {1'b1, 32'h4000_0000, 5'd1, 1'b0}) begin
      errors++;
      $display("FAIL mid_rst_next got v=%b d=%h t=%0d s=%b want 1 40000000 1 0", bus.res_valid,
               bus.res_data, bus.res_tag, bus.res_src);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [37:0]      sb[$];
    logic [37:0]      e;
    logic             pend[2];
    logic [31:0]      pdat[2];
    logic [TAG_W-1:0] ptag[2];
    int               bad = 0;
    do_reset();
    pend = '{1'b0, 1'b0};
    for (int c = 0; c < 10000; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 2) != 0) begin
          pend[p] = 1'b1;
          pdat[p] = $urandom >> $urandom_range(0, 31);
          if ($urandom_range(0, 1) == 1) pdat[p] = ~pdat[p] + 32'd1;
          ptag[p] = 5'($urandom);
        end
      end
      bus.req0_valid = pend[0]; bus.req0_data = pdat[0]; bus.req0_tag = ptag[0];
      bus.req1_valid = pend[1]; bus.req1_data = pdat[1]; bus.req1_tag = ptag[1];
      bus.res_ready  = ($urandom_range(0, 3) != 0);
      #1;
      if (bus.req0_ready && bus.req1_ready) begin
        checks++; errors++; $display("FAIL rand_two_ready at cycle %0d", c);
      end
      if (bus.res_valid && bus.res_ready) begin
        checks++;
        e = (sb.size() > 0) ? sb.pop_front() : 38'h3F_FFFF_FFFF;
        if ({bus.res_data, bus.res_tag, bus.res_src} !== e) begin
          errors++;
          if (bad++ < 10)
            $display("FAIL rand_result cycle %0d got d=%h t=%0d s=%b want d=%h t=%0d s=%b", c,
                     bus.res_data, bus.res_tag, bus.res_src, e[37:6], e[5:1], e[0]);
        end
      end
      if (bus.req0_valid && bus.req0_ready) begin
        sb.push_back({ref_itof(pdat[0]), ptag[0], 1'b0}); pend[0] = 1'b0;
      end
      if (bus.req1_valid && bus.req1_ready) begin
        sb.push_back({ref_itof(pdat[1]), ptag[1], 1'b1}); pend[1] = 1'b0;
      end
      @(negedge clk);
    end
    idle_inputs();
    for (int c = 0; c < 10; c++) begin
      #1;
      if (bus.res_valid) begin
        checks++;
        e = (sb.size() > 0) ? sb.pop_front() : 38'h3F_FFFF_FFFF;
        if ({bus.res_data, bus.res_tag, bus.res_src} !== e) begin
          errors++; $display("FAIL rand_drain got d=%h want d=%h", bus.res_data, e[37:6]);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (sb.size() != 0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL rand_loss got %0d pending busy=%b want 0 0", sb.size(), bus.busy);
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_single();
    test_corners();
    test_contention();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
